// File: rtl/latch_scan_pkg.sv
// rtl/latch_scan_pkg.sv - shared types and helpers for the latch bank and digit scanner
package latch_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // clog2 that never returns 0, so single-value ranges still get a 1-bit field
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/latch_cell.sv
// rtl/latch_cell.sv - one clocked data latch channel with complementary outputs
module latch_cell #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] nq_q;

  // nq is a register of its own so it never shows a decode glitch against q
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= '0;
      nq_q <= '1;
    end else if (cap) begin
      q_q  <= d;
      nq_q <= ~d;
    end
  end

  assign q  = q_q;
  assign nq = nq_q;

endmodule

// File: rtl/latch_scan_bank.sv
// rtl/latch_scan_bank.sv - latched channel bank with multiplexed 7-segment digit scanner
module latch_scan_bank
  import latch_scan_pkg::*;
#(
  parameter int  WIDTH        = 4,
  parameter int  CHANNELS     = 4,
  parameter int  SCAN_DIV     = 1000,
  parameter int  BLANK_CYCLES = 2,
  localparam int SEL_W        = safe_clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      nena,
  input  logic                      freeze,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH*CHANNELS-1:0] q,
  output logic [WIDTH*CHANNELS-1:0] nq,
  output logic [WIDTH-1:0]          scan_data,
  output logic [CHANNELS-1:0]       scan_sel,
  output logic                      scan_blank,
  output logic                      frame_tick
);

  localparam int CNT_W = safe_clog2(SCAN_DIV);

  generate
    if (SCAN_DIV <= BLANK_CYCLES || CHANNELS < 2) begin : g_bad_params
      $error("latch_scan_bank: requires SCAN_DIV > BLANK_CYCLES and CHANNELS >= 2");
    end
  endgenerate

  logic             cap_en;
  logic [WIDTH-1:0] q_arr [CHANNELS];

  assign cap_en = ena & ~nena & ~freeze;

  // an out-of-range wr_sel matches no cell, so it is dropped without extra logic
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    latch_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .rst (rst),
      .cap (cap_en && (wr_sel == SEL_W'(i))),
      .d   (d),
      .q   (q_arr[i]),
      .nq  (nq[i*WIDTH +: WIDTH])
    );
    assign q[i*WIDTH +: WIDTH] = q_arr[i];
  end

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]    scan_data_q, scan_data_d;
  logic [CHANNELS-1:0] scan_sel_q, scan_sel_d;
  logic                scan_blank_q, scan_blank_d;
  logic                frame_tick_q, frame_tick_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    state_d = state_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d   = '0;
      idx_d   = (idx_q == SEL_W'(CHANNELS - 1)) ? '0 : idx_q + SEL_W'(1);
      state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
    end else if (state_q == BLANK && (int'(cnt_q) + 1 >= BLANK_CYCLES)) begin
      state_d = SHOW;
    end

    // outputs are derived from next state so they line up with the state registers
    scan_sel_d   = '0;
    scan_blank_d = 1'b1;
    scan_data_d  = scan_data_q;
    if (state_d == SHOW) begin
      scan_sel_d   = CHANNELS'(1) << idx_d;
      scan_blank_d = 1'b0;
      scan_data_d  = q_arr[idx_d];
    end
    frame_tick_d = (cnt_d == CNT_W'(SCAN_DIV - 1)) && (idx_d == SEL_W'(CHANNELS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      scan_data_q  <= '0;
      scan_sel_q   <= '0;
      scan_blank_q <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      scan_data_q  <= scan_data_d;
      scan_sel_q   <= scan_sel_d;
      scan_blank_q <= scan_blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign scan_data  = scan_data_q;
  assign scan_sel   = scan_sel_q;
  assign scan_blank = scan_blank_q;
  assign frame_tick = frame_tick_q;

endmodule
